// File: rtl/db15_serial_reader_pkg.sv
// Shared constants, button bit positions and FSM state type for the DB15 joystick reader.
package db15_pkg;

  localparam int NBITS       = 24;
  localparam int PLAYER_BITS = 12;

  // Bit positions inside one player's joystick word
  localparam int R     = 0;
  localparam int L     = 1;
  localparam int D     = 2;
  localparam int U     = 3;
  localparam int A     = 4;
  localparam int B     = 5;
  localparam int C     = 6;
  localparam int DB    = 7;
  localparam int E     = 8;
  localparam int F     = 9;
  localparam int START = 10;
  localparam int COIN  = 11;

  typedef enum logic [2:0] {
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    UPDATE,
    GAP
  } state_t;

endpackage

// File: rtl/db15_serial_reader_sync.sv
// Two-flop synchronizer for the adapter's serial data; idles high (buttons released).
module db15_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic data_p0;
  logic data_p1;

  // Two register stages to settle the asynchronous adapter line
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      data_p0 <= d;
      data_p1 <= data_p0;
    end
  end

  assign q = data_p1;

endmodule

// File: rtl/db15_serial_reader.sv
// DB15 two-player adapter reader: drives load/clock lines, shifts in 24 active-low
// bits and publishes both joystick words together with a one-cycle frame strobe.
module db15_serial_reader #(
  parameter int DIV = 16,
  parameter int GAP = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_strobe
);

  import db15_pkg::*;

  localparam int HC_W = $clog2(DIV);
  localparam int GC_W = $clog2(GAP + 1);

  logic [HC_W-1:0]  hc;
  logic [GC_W-1:0]  gc;
  logic [4:0]       bit_cnt;
  logic [NBITS-1:0] sreg;
  state_t           state;
  logic             data_s;
  logic             tick;
  logic             bit_bad;

  db15_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (joy_data),
    .q     (data_s)
  );

  assign tick    = (hc == HC_W'(DIV - 1));
  assign bit_bad = (bit_cnt >= 5'(NBITS));

  // Frame sequencer; the line outputs are registered from the current state, so every
  // phase appears on the pins one clk after the state is entered and lasts DIV clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LOAD;
      hc           <= '0;
      gc           <= '0;
      bit_cnt      <= '0;
      sreg         <= '0;
      joystick1    <= '0;
      joystick2    <= '0;
      frame_strobe <= 1'b0;
      joy_clk      <= 1'b0;
      joy_load     <= 1'b1;
    end else begin
      joy_load     <= (state != LOAD);
      joy_clk      <= (state == SHIFT_HI);
      frame_strobe <= 1'b0;
      hc           <= tick ? '0 : hc + 1'b1;
      case (state)
        LOAD: begin
          if (tick) begin
            state   <= SHIFT_LO;
            bit_cnt <= '0;
          end
        end
        SHIFT_LO: begin
          if (bit_bad) begin
            state <= LOAD;
            hc    <= '0;
          end else if (tick) begin
            sreg[bit_cnt] <= data_s;
            state         <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (bit_bad) begin
            state <= LOAD;
            hc    <= '0;
          end else if (tick) begin
            bit_cnt <= bit_cnt + 1'b1;
            state   <= (bit_cnt == 5'(NBITS - 1)) ? UPDATE : SHIFT_LO;
          end
        end
        UPDATE: begin
          // Wire bits are active-low; both words and the strobe change in this one clk
          joystick1    <= {4'b0, ~sreg[PLAYER_BITS-1:0]};
          joystick2    <= {4'b0, ~sreg[NBITS-1:PLAYER_BITS]};
          frame_strobe <= 1'b1;
          state        <= db15_pkg::GAP;
          hc           <= '0;
          gc           <= '0;
        end
        db15_pkg::GAP: begin
          if (tick) begin
            if (gc == GC_W'(GAP - 1)) begin
              state <= LOAD;
              gc    <= '0;
            end else begin
              gc <= gc + 1'b1;
            end
          end
        end
        default: begin
          state <= LOAD;
          hc    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_db15_serial_reader.sv
// Bench for db15_serial_reader: adapter model (two chained 8+8+8 shift registers),
// a frame-timing reference model, per-cycle compare and directed scenarios.
module tb_db15_serial_reader;

  localparam int DIV     = 16;
  localparam int GAPN    = 64;
  localparam int PERIOD  = DIV + 48 * DIV + 1 + GAPN * DIV;
  localparam int UPD_OFS = DIV + 48 * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_strobe;

  int checks = 0;
  int errors = 0;

  logic [11:0] p1 = 12'h000;
  logic [11:0] p2 = 12'h000;

  always #5 clk = ~clk;

  db15_serial_reader #(.DIV(DIV), .GAP(GAPN)) dut (
    .clk          (clk),
    .reset        (reset),
    .joy_data     (joy_data),
    .joy_clk      (joy_clk),
    .joy_load     (joy_load),
    .joystick1    (joystick1),
    .joystick2    (joystick2),
    .frame_strobe (frame_strobe)
  );

  // Adapter: parallel load on falling load, shift toward the output on rising clock
  logic [23:0] adp = '1;
  always @(negedge joy_load) adp = ~{p2, p1};
  always @(posedge joy_clk) adp = {1'b1, adp[23:1]};
  assign joy_data = adp[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle position in the frame since reset release
  int          n = 0;
  bit          model_on = 0;
  logic [15:0] exp1 = '0;
  logic [15:0] exp2 = '0;
  logic [23:0] pend = '0;

  always @(posedge clk) begin
    int m;
    model_on = 1;
    if (reset) begin
      n    = 0;
      exp1 = '0;
      exp2 = '0;
    end else begin
      n++;
      m = (n - 1) % PERIOD;
      if (m == 0) pend = {p2, p1};
      if (m == UPD_OFS) begin
        exp1 = {4'b0, pend[11:0]};
        exp2 = {4'b0, pend[23:12]};
      end
    end
  end

  function automatic logic exp_load(input int cn);
    if (cn == 0) return 1'b1;
    return !(((cn - 1) % PERIOD) < DIV);
  endfunction

  function automatic logic exp_clk(input int cn);
    int s;
    if (cn == 0) return 1'b0;
    s = ((cn - 1) % PERIOD) - DIV;
    return (s >= 0) && (s < 48 * DIV) && ((s % (2 * DIV)) >= DIV);
  endfunction

  function automatic logic exp_strobe(input int cn);
    if (cn == 0) return 1'b0;
    return ((cn - 1) % PERIOD) == UPD_OFS;
  endfunction

  // Per-cycle comparison against the reference model
  always @(negedge clk) begin
    if (model_on) begin
      chk("cyc_joystick1", joystick1, exp1);
      chk("cyc_joystick2", joystick2, exp2);
      chk("cyc_strobe", frame_strobe, exp_strobe(n));
      chk("cyc_joy_load", joy_load, exp_load(n));
      chk("cyc_joy_clk", joy_clk, exp_clk(n));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_strobe(input int limit, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!frame_strobe && cyc < limit);
    if (!frame_strobe) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout: no strobe within %0d clk", limit);
    end
  endtask

  task automatic wait_load_low(input int limit);
    int cyc = 0;
    do begin
      step();
      cyc++;
    end while (joy_load && cyc < limit);
    if (joy_load) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: joy_load high for %0d clk", limit);
    end
  endtask

  initial begin
    int c;
    int rises;
    int lows;
    logic prev;

    // Reset held 5 clk
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_joystick1", joystick1, 16'h0000);
      chk("rst_joystick2", joystick2, 16'h0000);
      chk("rst_strobe", frame_strobe, 1'b0);
      chk("rst_joy_load", joy_load, 1'b1);
      chk("rst_joy_clk", joy_clk, 1'b0);
    end
    reset = 1'b0;
    step();
    chk("load_fall_first", joy_load, 1'b0);
    wait_strobe(2000, c);
    chk("strobe_latency", c, 784);
    chk("idle_joystick1", joystick1, 16'h0000);
    chk("idle_joystick2", joystick2, 16'h0000);

    // Pressed pattern A51 / 3C0 from a fresh reset
    reset = 1'b1;
    p1 = 12'hA51;
    p2 = 12'h3C0;
    repeat (5) step();
    reset = 1'b0;
    wait_strobe(2000, c);
    chk("pat_joystick1", joystick1, 16'h0A51);
    chk("pat_joystick2", joystick2, 16'h03C0);

    // Frame timing measurement, strobe to strobe
    c = 0;
    rises = 0;
    lows = 0;
    prev = joy_clk;
    do begin
      step();
      c++;
      if (joy_clk && !prev) rises++;
      prev = joy_clk;
      if (!joy_load) lows++;
    end while (!frame_strobe && c < 4000);
    chk("frame_period", c, 1809);
    chk("clk_rises", rises, 24);
    chk("load_low_width", lows, 16);

    // Pressed bits change mid-shift: frame keeps the pattern loaded at its start
    wait_load_low(2000);
    repeat (300) step();
    p1 = 12'h5C3;
    p2 = 12'h0F1;
    wait_strobe(2000, c);
    chk("midshift_old_j1", joystick1, 16'h0A51);
    chk("midshift_old_j2", joystick2, 16'h03C0);
    wait_strobe(2000, c);
    chk("midshift_new_j1", joystick1, 16'h05C3);
    chk("midshift_new_j2", joystick2, 16'h00F1);

    // Reset during bit 7 of a frame
    p1 = 12'hA51;
    p2 = 12'h3C0;
    wait_strobe(2000, c);
    chk("pre_abort_j1", joystick1, 16'h0A51);
    wait_load_low(2000);
    repeat (16 + 32 * 7 + 5) step();
    p1 = 12'h1E7;
    p2 = 12'h2B4;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_joystick1", joystick1, 16'h0000);
    chk("abort_joystick2", joystick2, 16'h0000);
    chk("abort_strobe", frame_strobe, 1'b0);
    chk("abort_joy_load", joy_load, 1'b1);
    chk("abort_joy_clk", joy_clk, 1'b0);
    wait_strobe(2000, c);
    chk("abort_strobe_lat", c, 785);
    chk("reload_joystick1", joystick1, 16'h01E7);
    chk("reload_joystick2", joystick2, 16'h02B4);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
